// File: rtl/dsp_file_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dsp_file_arbiter_pkg
// Shared definitions for the DSP file-bank arbiter and its schedulers:
//   - arbiter state encodings (8-bit, same width as the equation engines)
//   - default abort timeout and file-port widths
//   - idx_width(): index width helper that never returns zero
// ---------------------------------------------------------------------------
package dsp_file_arbiter_pkg;

  localparam int FILE_NUM_W      = 8;
  localparam int FILE_DW         = 32;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'h00,
    ST_GRANT  = 8'h01,
    ST_ACTIVE = 8'h02
  } arb_state_e;

  // Width of an index able to address n items; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dsp_rr_pick.sv
// ---------------------------------------------------------------------------
// dsp_rr_pick
// Combinational round-robin priority picker. Searches req starting at
// last+1 and wrapping around; the first requester found wins.
// Ports:
//   req   in  NUM_EQ  request vector
//   last  in  IW      index of the previous winner
//   valid out 1       at least one request present
//   idx   out IW      winning index (0 when valid is low)
// ---------------------------------------------------------------------------
module dsp_rr_pick
  import dsp_file_arbiter_pkg::*;
#(
  parameter int NUM_EQ = 4
) (
  input  logic [NUM_EQ-1:0]                 req,
  input  logic [idx_width(NUM_EQ)-1:0]      last,
  output logic                              valid,
  output logic [idx_width(NUM_EQ)-1:0]      idx
);

  localparam int IW = idx_width(NUM_EQ);

  // cand[k] is the engine at search position k (k = 0 is last+1).
  logic [IW-1:0]     cand [NUM_EQ];
  logic [NUM_EQ-1:0] rot_req;

  for (genvar gi = 0; gi < NUM_EQ; gi++) begin : g_rot
    assign cand[gi]    = IW'((int'(last) + 1 + gi) % NUM_EQ);
    assign rot_req[gi] = req[cand[gi]];
  end

  // Scan from the far end so the nearest position overwrites last.
  always_comb begin
    valid = |rot_req;
    idx   = '0;
    for (int k = NUM_EQ - 1; k >= 0; k--) begin
      if (rot_req[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/dsp_file_arbiter.sv
// ---------------------------------------------------------------------------
// dsp_file_arbiter
// Round-robin arbiter sharing the single DSP file-bank port among NUM_EQ
// equation engines. One full transaction (strobe, active high, active low)
// is granted at a time; stalled grants are aborted after TIMEOUT cycles.
// Ports:
//   wb_clk, wb_rst        clock / synchronous active-high reset
//   eq_file_num           per-engine file number, engine i at [8i+7:8i]
//   eq_file_read/_write   per-engine level strobes
//   eq_file_write_data    per-engine write data, engine i at [dw*i +: dw]
//   eq_file_active        file_active routed to the granted engine only
//   eq_file_read_data     file_read_data broadcast
//   file_*                file-bank side of the shared port
//   grant                 one-hot current owner (0 when idle)
//   timeout_error         one-cycle pulse on abort
//   protocol_error        one-cycle pulse when a winner asserts read+write
// ---------------------------------------------------------------------------
module dsp_file_arbiter
  import dsp_file_arbiter_pkg::*;
#(
  parameter int NUM_EQ  = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int dw      = FILE_DW
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  input  logic [NUM_EQ*FILE_NUM_W-1:0] eq_file_num,
  input  logic [NUM_EQ-1:0]            eq_file_read,
  input  logic [NUM_EQ-1:0]            eq_file_write,
  input  logic [NUM_EQ*dw-1:0]         eq_file_write_data,
  output logic [NUM_EQ-1:0]            eq_file_active,
  output logic [dw-1:0]                eq_file_read_data,
  output logic [FILE_NUM_W-1:0]        file_num,
  output logic                         file_read,
  output logic                         file_write,
  output logic [dw-1:0]                file_write_data,
  input  logic                         file_active,
  input  logic [dw-1:0]                file_read_data,
  output logic [NUM_EQ-1:0]            grant,
  output logic                         timeout_error,
  output logic                         protocol_error
);

  localparam int IW = idx_width(NUM_EQ);
  localparam int TW = idx_width(TIMEOUT);

  arb_state_e            state_q;
  logic [NUM_EQ-1:0]     grant_q;
  logic [IW-1:0]         owner_q;
  logic [IW-1:0]         last_q;
  logic [TW-1:0]         timer_q;
  logic [FILE_NUM_W-1:0] file_num_q;
  logic                  file_read_q;
  logic                  file_write_q;
  logic [dw-1:0]         file_wdata_q;
  logic                  timeout_error_q;
  logic                  protocol_error_q;

  // Per-engine views of the packed input buses.
  logic [FILE_NUM_W-1:0] num_arr   [NUM_EQ];
  logic [dw-1:0]         wdata_arr [NUM_EQ];
  logic [NUM_EQ-1:0]     req;

  for (genvar gi = 0; gi < NUM_EQ; gi++) begin : g_unpack
    assign num_arr[gi]   = eq_file_num[FILE_NUM_W*gi +: FILE_NUM_W];
    assign wdata_arr[gi] = eq_file_write_data[dw*gi +: dw];
  end

  assign req = eq_file_read | eq_file_write;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  dsp_rr_pick #(
    .NUM_EQ (NUM_EQ)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Source engine: the fresh winner while idle, the owner otherwise.
  logic [IW-1:0]         sel_idx;
  logic                  sel_rd;
  logic                  sel_wr;
  logic [FILE_NUM_W-1:0] sel_num;
  logic [dw-1:0]         sel_wdata;

  assign sel_idx   = (state_q == ST_IDLE) ? pick_idx : owner_q;
  assign sel_rd    = eq_file_read[sel_idx];
  assign sel_wr    = eq_file_write[sel_idx];
  assign sel_num   = num_arr[sel_idx];
  assign sel_wdata = wdata_arr[sel_idx];

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q          <= ST_IDLE;
      grant_q          <= '0;
      owner_q          <= '0;
      last_q           <= IW'(NUM_EQ - 1);
      timer_q          <= '0;
      file_num_q       <= '0;
      file_read_q      <= 1'b0;
      file_write_q     <= 1'b0;
      file_wdata_q     <= '0;
      timeout_error_q  <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      timeout_error_q  <= 1'b0;
      protocol_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A stray file_active here is deliberately ignored.
          if (pick_valid) begin
            state_q          <= ST_GRANT;
            owner_q          <= pick_idx;
            grant_q          <= NUM_EQ'(1) << pick_idx;
            timer_q          <= '0;
            file_num_q       <= sel_num;
            file_wdata_q     <= sel_wdata;
            // Read wins when both strobes are raised.
            file_read_q      <= sel_rd;
            file_write_q     <= sel_wr & ~sel_rd;
            protocol_error_q <= sel_rd & sel_wr;
          end
        end
        ST_GRANT: begin
          if (file_active) begin
            state_q      <= ST_ACTIVE;
            file_read_q  <= 1'b0;
            file_write_q <= 1'b0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            last_q          <= owner_q;
            file_read_q     <= 1'b0;
            file_write_q    <= 1'b0;
            timeout_error_q <= 1'b1;
          end else if (!(sel_rd | sel_wr)) begin
            // Engine withdrew before the bank answered.
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_q       <= owner_q;
            file_read_q  <= 1'b0;
            file_write_q <= 1'b0;
          end else begin
            timer_q      <= timer_q + TW'(1);
            file_num_q   <= sel_num;
            file_wdata_q <= sel_wdata;
            file_read_q  <= sel_rd;
            file_write_q <= sel_wr & ~sel_rd;
          end
        end
        ST_ACTIVE: begin
          file_read_q  <= 1'b0;
          file_write_q <= 1'b0;
          if (!file_active) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= owner_q;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          grant_q      <= '0;
          file_read_q  <= 1'b0;
          file_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Handshake return path is combinational so engine latency is unchanged.
  logic in_xfer;
  assign in_xfer = (state_q == ST_GRANT) || (state_q == ST_ACTIVE);

  assign eq_file_active    = {NUM_EQ{file_active & in_xfer}} & grant_q;
  assign eq_file_read_data = file_read_data;

  assign file_num        = file_num_q;
  assign file_read       = file_read_q;
  assign file_write      = file_write_q;
  assign file_write_data = file_wdata_q;
  assign grant           = grant_q;
  assign timeout_error   = timeout_error_q;
  assign protocol_error  = protocol_error_q;

endmodule

// File: doc/dsp_file_arbiter.md
# dsp_file_arbiter

Round-robin arbiter that shares the single DSP file-bank port (file_num / file_read / file_write / file_write_data / file_active / file_read_data) among up to NUM_EQ equation engines. It sits between the equation engines (sum, mean, min/max, …) and the file bank inside the DSP slave. It grants one complete file transaction at a time: strobe, active high, active low. It routes the handshake back to the granted engine only, and it aborts stalled transactions with a timeout.

## Interface
- NUM_EQ, 4: number of requesting engines (2..8).
- TIMEOUT, 1024: cycles allowed in GRANT for file_active to rise before abort.
- dw, 32: file data width.
- wb_clk  in  1  clock, all logic on rising edge.
- wb_rst  in  1  reset; synchronous, active-high.
- eq_file_num  in  NUM_EQ*8  per-engine file number, engine i at [8i+7:8i].
- eq_file_read  in  NUM_EQ  per-engine read strobe (level, held until eq_file_active seen).
- eq_file_write  in  NUM_EQ  per-engine write strobe (same protocol).
- eq_file_write_data  in  NUM_EQ*dw  per-engine write data.
- eq_file_active  out  NUM_EQ  file_active routed to the granted engine only; other bits 0.
- eq_file_read_data  out  dw  file_read_data broadcast to all engines.
- file_num  out  8  to file bank.
- file_read  out  1  to file bank.
- file_write  out  1  to file bank.
- file_write_data  out  dw  to file bank.
- file_active  in  1  file bank busy/ack.
- file_read_data  in  dw  file bank read data.
- grant  out  NUM_EQ  one-hot current owner; 0 when idle.
- timeout_error  out  1  one-cycle pulse on abort.
- protocol_error  out  1  one-cycle pulse when granted engine raises read and write together.

## Operation
- Request i = eq_file_read[i] | eq_file_write[i].
- States: IDLE, GRANT, ACTIVE.
- IDLE: if any request, pick the first requester searching from last_grant+1 with wrap-around. Register grant and file_num/file_write_data from that engine. Register file_read/file_write from its strobes. Go to GRANT.
- If the chosen engine has both strobes set: file_read=1, file_write=0, protocol_error pulse. Read wins.
- GRANT: file_read/file_write/file_num/file_write_data re-registered each cycle from the granted engine.
  - On file_active=1: clear file_read/file_write, go to ACTIVE.
  - If timer reaches TIMEOUT-1: clear strobes, clear grant, pulse timeout_error, last_grant<=aborted index, go to IDLE.
  - If the granted engine drops both strobes before file_active rises: release to IDLE and update last_grant.
- ACTIVE: hold file_num and strobes low. On file_active=0: clear grant, last_grant<=owner, go to IDLE.
- eq_file_active[i] = file_active & grant[i] & (state==GRANT|ACTIVE). This is combinational so engine latency is unchanged.
- eq_file_read_data = file_read_data, combinational.

## Timing
- Reset values:
  - state=IDLE; grant=0; last_grant=NUM_EQ-1 (first search starts at engine 0).
  - file_num=0; file_read=0; file_write=0; file_write_data=0; timer=0.
  - timeout_error=0; protocol_error=0.
- Grant latency: request present in IDLE at cycle N gives grant and file strobe valid at cycle N+1.
- The strobe falls in the cycle after file_active is first seen high.
- After ACTIVE ends there is at least one IDLE cycle before the next grant. A back-to-back single requester therefore sees a 1-cycle gap.
- Arbitration is fair: with all engines requesting, grants are issued in order last+1, last+2, … No engine waits more than NUM_EQ-1 transactions.
- Timer resets on every entry to GRANT and counts GRANT cycles only. ACTIVE has no timeout.
- file_active high while in IDLE (stray): ignored, no grant change, eq_file_active all 0.
- Requests arriving while not IDLE are held off; engines keep strobes asserted.
- wb_rst mid-transaction: immediate return to reset values; in-flight transaction abandoned, no error pulse.

## Structure
- Shared package/include: state encodings (8-bit localparams, matching the engine style), default TIMEOUT, file-port widths.
- One sub-module: dsp_rr_pick. It is a combinational round-robin priority picker with inputs req[NUM_EQ] and last[idx] and outputs valid and idx. It is reused by future DSP schedulers.
- Top holds the FSM, timer, output registers and routing muxes.

## Test plan
- Single engine 2 read, file bank acks after 3 cycles for 2 cycles → grant=4'b0100 one cycle after request; file_read high 4 cycles; eq_file_active[2] mirrors file_active; grant returns to 0.
- Engines 0,1,3 request simultaneously, last_grant reset → grants in order 0,1,3, each separated by ≥1 IDLE cycle; then engine 0 re-requests and is served after 3.
- Engine 1 write, data 0xDEADBEEF, file_num 8'h05 → file_write_data=0xDEADBEEF, file_num=8'h05 at the bank; eq_file_active[0,2,3] stay 0.
- TIMEOUT=16, file_active never rises → timeout_error pulses at GRANT cycle 16; strobes and grant clear; next requester is granted.
- Engine 0 raises read and write together → file_read=1, file_write=0, protocol_error one-cycle pulse.
- wb_rst asserted while in ACTIVE → next cycle all outputs at reset values; a subsequent request from engine 0 is granted normally.
